// File: rtl/mouse_master_sm_pkg.sv
// Shared definitions for the PS/2 mouse host state machine: state encodings,
// command/response bytes, frame error codes and small decode helpers.
package mouse_master_sm_pkg;

  typedef enum logic [3:0] {
    ST_INIT_WAIT    = 4'd0,
    ST_SEND_FF      = 4'd1,
    ST_WAIT_SENT_FF = 4'd2,
    ST_WAIT_FA      = 4'd3,
    ST_WAIT_AA      = 4'd4,
    ST_WAIT_00      = 4'd5,
    ST_SEND_F4      = 4'd6,
    ST_WAIT_SENT_F4 = 4'd7,
    ST_WAIT_FA_F4   = 4'd8,
    ST_READ_STATUS  = 4'd9,
    ST_READ_DX      = 4'd10,
    ST_READ_DY      = 4'd11,
    ST_INTERRUPT    = 4'd12
  } mouse_state_e;

  // Host-to-mouse commands
  localparam logic [7:0] CMD_RESET         = 8'hFF;
  localparam logic [7:0] CMD_ENABLE_REPORT = 8'hF4;

  // Mouse-to-host responses
  localparam logic [7:0] RSP_ACK          = 8'hFA;
  localparam logic [7:0] RSP_SELF_TEST_OK = 8'hAA;
  localparam logic [7:0] RSP_MOUSE_ID     = 8'h00;

  // Receiver frame status
  localparam logic [1:0] ERR_NONE = 2'b00;

  // States in which the receiver output is consumed.
  function automatic logic is_receive_state(mouse_state_e s);
    case (s)
      ST_WAIT_FA, ST_WAIT_AA, ST_WAIT_00, ST_WAIT_FA_F4,
      ST_READ_STATUS, ST_READ_DX, ST_READ_DY: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  // States guarded by the shared cycle counter (power-up wait or response timeout).
  function automatic logic is_timed_state(mouse_state_e s);
    case (s)
      ST_INIT_WAIT, ST_WAIT_SENT_FF, ST_WAIT_FA, ST_WAIT_AA, ST_WAIT_00,
      ST_WAIT_SENT_F4, ST_WAIT_FA_F4: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

  // A received byte is accepted only with a clean frame and the expected value.
  function automatic logic resp_match(logic [7:0] data, logic [1:0] err, logic [7:0] expected);
    return (err == ERR_NONE) && (data == expected);
  endfunction

  // Saturate a movement byte when the mouse reports overflow on that axis.
  function automatic logic [7:0] clamp_move(logic [7:0] move, logic ovf, logic sign);
    if (!ovf) return move;
    return sign ? 8'h80 : 8'h7F;
  endfunction

endpackage

// File: rtl/mouse_master_sm_if.sv
// Bus between the mouse host FSM and the PS/2 transceiver / packet consumer.
//
// Handshake: all strobes are single-cycle pulses, no back-pressure.
//   SEND_BYTE  (master->transceiver) requests a transmit of BYTE_TO_SEND; the byte
//              stays stable until BYTE_SENT pulses back.
//   BYTE_READY (transceiver->master) qualifies BYTE_READ/BYTE_ERROR_CODE for that
//              cycle only; it is consumed only while READ_ENABLE is high.
//   SEND_INTERRUPT (master->consumer) marks the cycle a new packet lands on MOUSE_*.
interface mouse_master_sm_if;
  logic       SEND_BYTE;
  logic [7:0] BYTE_TO_SEND;
  logic       BYTE_SENT;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;
  logic [7:0] MOUSE_DX;
  logic [7:0] MOUSE_DY;
  logic [7:0] MOUSE_DZ;
  logic [7:0] MOUSE_STATUS;
  logic       SEND_INTERRUPT;

  modport master (
    output SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
    output MOUSE_DX, MOUSE_DY, MOUSE_DZ, MOUSE_STATUS, SEND_INTERRUPT,
    input  BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
  );

  modport slave (
    input  SEND_BYTE, BYTE_TO_SEND, READ_ENABLE,
    input  MOUSE_DX, MOUSE_DY, MOUSE_DZ, MOUSE_STATUS, SEND_INTERRUPT,
    output BYTE_SENT, BYTE_READ, BYTE_ERROR_CODE, BYTE_READY
  );
endinterface

// File: rtl/mouse_timeout_counter.sv
// Cycle counter shared by the power-up wait and the response timeouts.
// terminal is high in the last cycle of a window of 'limit' cycles.
module mouse_timeout_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             terminal
);

  logic [WIDTH-1:0] count_q;

  assign terminal = enable && ((count_q + WIDTH'(1)) >= limit);

  // Count while enabled, restart on clear, park at the terminal value.
  always_ff @(posedge CLK) begin
    if (RESET || clear) begin
      count_q <= '0;
    end else if (enable && !terminal) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mouse_master_sm.sv
// PS/2 mouse host: waits for power-up, resets the mouse (FF -> FA, AA, 00),
// enables streaming (F4 -> FA), then assembles 3-byte packets and publishes
// them with a one-cycle SEND_INTERRUPT. Any protocol error or timeout during
// init, or a bad frame while streaming, re-runs the whole init sequence.
module mouse_master_sm
  import mouse_master_sm_pkg::*;
#(
  parameter int unsigned INIT_WAIT_CYCLES    = 5_000_000,
  parameter int unsigned RESP_TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                      CLK,
  input  logic                      RESET,
  mouse_master_sm_if.master         bus,
  output logic [3:0]                CURRENT_STATE
);

  localparam int unsigned TW = 32;
  localparam logic [TW-1:0] INIT_LIMIT = TW'(INIT_WAIT_CYCLES);
  localparam logic [TW-1:0] RESP_LIMIT = TW'(RESP_TIMEOUT_CYCLES);

  mouse_state_e state_q, next_state;

  logic [7:0] shadow_status_q, shadow_dx_q, shadow_dy_q;
  logic [7:0] shadow_status_d, shadow_dx_d, shadow_dy_d;

  logic       send_byte_q;
  logic [7:0] byte_to_send_q;
  logic       read_enable_q;
  logic       send_interrupt_q;
  logic [7:0] mouse_dx_q, mouse_dy_q, mouse_status_q;

  logic       timer_done;
  logic       rx_ok;
  logic       rx_bad;

  assign rx_ok  = bus.BYTE_READY && (bus.BYTE_ERROR_CODE == ERR_NONE);
  assign rx_bad = bus.BYTE_READY && (bus.BYTE_ERROR_CODE != ERR_NONE);

  // Counter restarts on every state change; the limit depends on which wait is active.
  mouse_timeout_counter #(.WIDTH(TW)) u_timer (
    .CLK      (CLK),
    .RESET    (RESET),
    .clear    (next_state != state_q),
    .enable   (is_timed_state(state_q)),
    .limit    ((state_q == ST_INIT_WAIT) ? INIT_LIMIT : RESP_LIMIT),
    .terminal (timer_done)
  );

  // Next-state and shadow-register decode.
  always_comb begin
    next_state      = state_q;
    shadow_status_d = shadow_status_q;
    shadow_dx_d     = shadow_dx_q;
    shadow_dy_d     = shadow_dy_q;
    case (state_q)
      ST_INIT_WAIT:    if (timer_done) next_state = ST_SEND_FF;
      ST_SEND_FF:      next_state = ST_WAIT_SENT_FF;
      ST_WAIT_SENT_FF: begin
        if (bus.BYTE_SENT)   next_state = ST_WAIT_FA;
        else if (timer_done) next_state = ST_INIT_WAIT;
      end
      ST_WAIT_FA: begin
        if (bus.BYTE_READY)
          next_state = resp_match(bus.BYTE_READ, bus.BYTE_ERROR_CODE, RSP_ACK) ? ST_WAIT_AA : ST_INIT_WAIT;
        else if (timer_done) next_state = ST_INIT_WAIT;
      end
      ST_WAIT_AA: begin
        if (bus.BYTE_READY)
          next_state = resp_match(bus.BYTE_READ, bus.BYTE_ERROR_CODE, RSP_SELF_TEST_OK) ? ST_WAIT_00 : ST_INIT_WAIT;
        else if (timer_done) next_state = ST_INIT_WAIT;
      end
      ST_WAIT_00: begin
        if (bus.BYTE_READY)
          next_state = resp_match(bus.BYTE_READ, bus.BYTE_ERROR_CODE, RSP_MOUSE_ID) ? ST_SEND_F4 : ST_INIT_WAIT;
        else if (timer_done) next_state = ST_INIT_WAIT;
      end
      ST_SEND_F4:      next_state = ST_WAIT_SENT_F4;
      ST_WAIT_SENT_F4: begin
        if (bus.BYTE_SENT)   next_state = ST_WAIT_FA_F4;
        else if (timer_done) next_state = ST_INIT_WAIT;
      end
      ST_WAIT_FA_F4: begin
        if (bus.BYTE_READY)
          next_state = resp_match(bus.BYTE_READ, bus.BYTE_ERROR_CODE, RSP_ACK) ? ST_READ_STATUS : ST_INIT_WAIT;
        else if (timer_done) next_state = ST_INIT_WAIT;
      end
      ST_READ_STATUS: begin
        if (rx_ok) begin
          shadow_status_d = bus.BYTE_READ;
          next_state      = ST_READ_DX;
        end else if (rx_bad) begin
          next_state = ST_INIT_WAIT;
        end
      end
      ST_READ_DX: begin
        if (rx_ok) begin
          shadow_dx_d = bus.BYTE_READ;
          next_state  = ST_READ_DY;
        end else if (rx_bad) begin
          next_state = ST_INIT_WAIT;
        end
      end
      ST_READ_DY: begin
        if (rx_ok) begin
          shadow_dy_d = bus.BYTE_READ;
          next_state  = ST_INTERRUPT;
        end else if (rx_bad) begin
          next_state = ST_INIT_WAIT;
        end
      end
      ST_INTERRUPT:    next_state = ST_READ_STATUS;
      default:         next_state = ST_INIT_WAIT;
    endcase
  end

  // State, shadows and registered outputs; outputs are decoded from next_state
  // so they line up with the state they belong to. The packet is published from
  // the *_d shadows so the final byte is already visible during INTERRUPT.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q          <= ST_INIT_WAIT;
      shadow_status_q  <= 8'h00;
      shadow_dx_q      <= 8'h00;
      shadow_dy_q      <= 8'h00;
      send_byte_q      <= 1'b0;
      byte_to_send_q   <= 8'h00;
      read_enable_q    <= 1'b0;
      send_interrupt_q <= 1'b0;
      mouse_dx_q       <= 8'h00;
      mouse_dy_q       <= 8'h00;
      mouse_status_q   <= 8'h00;
    end else begin
      state_q          <= next_state;
      shadow_status_q  <= shadow_status_d;
      shadow_dx_q      <= shadow_dx_d;
      shadow_dy_q      <= shadow_dy_d;
      send_byte_q      <= (next_state == ST_SEND_FF) || (next_state == ST_SEND_F4);
      if (next_state == ST_SEND_FF)      byte_to_send_q <= CMD_RESET;
      else if (next_state == ST_SEND_F4) byte_to_send_q <= CMD_ENABLE_REPORT;
      read_enable_q    <= is_receive_state(next_state);
      send_interrupt_q <= (next_state == ST_INTERRUPT);
      if (next_state == ST_INTERRUPT) begin
        mouse_status_q <= shadow_status_d;
        mouse_dx_q     <= clamp_move(shadow_dx_d, shadow_status_d[6], shadow_status_d[4]);
        mouse_dy_q     <= clamp_move(shadow_dy_d, shadow_status_d[7], shadow_status_d[5]);
      end
    end
  end

  assign bus.SEND_BYTE      = send_byte_q;
  assign bus.BYTE_TO_SEND   = byte_to_send_q;
  assign bus.READ_ENABLE    = read_enable_q;
  assign bus.SEND_INTERRUPT = send_interrupt_q;
  assign bus.MOUSE_STATUS   = mouse_status_q;
  assign bus.MOUSE_DX       = mouse_dx_q;
  assign bus.MOUSE_DY       = mouse_dy_q;
  assign bus.MOUSE_DZ       = 8'h00;
  assign CURRENT_STATE      = state_q;

endmodule

// File: tb/tb_mouse_master_sm.sv
// Bench for mouse_master_sm with short init/timeout windows.
module tb_mouse_master_sm;

  localparam int INIT_W = 10;
  localparam int RESP_T = 50;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] current_state;

  mouse_master_sm_if mif();

  mouse_master_sm #(
    .INIT_WAIT_CYCLES    (INIT_W),
    .RESP_TIMEOUT_CYCLES (RESP_T)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .bus           (mif.master),
    .CURRENT_STATE (current_state)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];   // {status, dx, dy, dz}

  typedef struct {
    logic [7:0] data;
    logic [1:0] err;
    logic [3:0] exp_state;
  } rx_vec_t;

  typedef struct {
    logic [7:0] status;
    logic [7:0] dx;
    logic [7:0] dy;
    logic [7:0] exp_dx;
    logic [7:0] exp_dy;
  } pkt_vec_t;

  rx_vec_t  init_tbl[3];
  pkt_vec_t pkt_tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every SEND_INTERRUPT pops one expected packet; an unexpected one is an error.
  always begin
    @(posedge CLK);
    #1;
    if (mif.SEND_INTERRUPT === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_irq: got SEND_INTERRUPT=1 expected 0 (t=%0t)", $time);
      end else begin
        check("packet_out", {mif.MOUSE_STATUS, mif.MOUSE_DX, mif.MOUSE_DY, mif.MOUSE_DZ},
              exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_sent();
    mif.BYTE_SENT = 1'b1;
    tick();
    mif.BYTE_SENT = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] data, input logic [1:0] err);
    mif.BYTE_READ       = data;
    mif.BYTE_ERROR_CODE = err;
    mif.BYTE_READY      = 1'b1;
    tick();
    mif.BYTE_READY      = 1'b0;
    mif.BYTE_ERROR_CODE = 2'b00;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_state"},  current_state,        4'd0);
    check({tag, "_send"},   mif.SEND_BYTE,        1'b0);
    check({tag, "_tx"},     mif.BYTE_TO_SEND,     8'h00);
    check({tag, "_rden"},   mif.READ_ENABLE,      1'b0);
    check({tag, "_irq"},    mif.SEND_INTERRUPT,   1'b0);
    check({tag, "_mouse"},  {mif.MOUSE_STATUS, mif.MOUSE_DX, mif.MOUSE_DY, mif.MOUSE_DZ}, 32'h0);
  endtask

  task automatic hold_reset(input int n);
    RESET = 1'b1;
    repeat (n) tick();
    check_cleared("reset");
    RESET = 1'b0;
  endtask

  // Waits (bounded) for the SEND_BYTE pulse; returns the number of cycles waited.
  task automatic wait_send(output int cyc);
    cyc = 0;
    while (mif.SEND_BYTE !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  // Full init from reset release to streaming state 9.
  task automatic run_init();
    int cyc;
    wait_send(cyc);
    check("init_wait_len", cyc, INIT_W);
    check("send_ff_byte",  mif.BYTE_TO_SEND, 8'hFF);
    check("send_ff_state", current_state, 4'd1);
    tick();
    check("send_ff_pulse", mif.SEND_BYTE, 1'b0);
    check("wait_sent_ff",  current_state, 4'd2);
    check("ff_held",       mif.BYTE_TO_SEND, 8'hFF);
    pulse_sent();
    check("wait_fa_state", current_state, 4'd3);
    check("wait_fa_rden",  mif.READ_ENABLE, 1'b1);
    for (int i = 0; i < 3; i++) begin
      rx_byte(init_tbl[i].data, init_tbl[i].err);
      check($sformatf("init_rx%0d_state", i), current_state, init_tbl[i].exp_state);
    end
    check("send_f4_pulse", mif.SEND_BYTE, 1'b1);
    check("send_f4_byte",  mif.BYTE_TO_SEND, 8'hF4);
    tick();
    check("send_f4_once",  mif.SEND_BYTE, 1'b0);
    check("wait_sent_f4",  current_state, 4'd7);
    check("f4_held",       mif.BYTE_TO_SEND, 8'hF4);
    pulse_sent();
    check("wait_fa_f4",    current_state, 4'd8);
    rx_byte(8'hFA, 2'b00);
    check("streaming",     current_state, 4'd9);
    check("stream_rden",   mif.READ_ENABLE, 1'b1);
  endtask

  task automatic send_packet(input pkt_vec_t p);
    exp_q.push_back({p.status, p.exp_dx, p.exp_dy, 8'h00});
    rx_byte(p.status, 2'b00);
    check("pkt_state10", current_state, 4'd10);
    repeat ($urandom_range(0, 3)) tick();
    rx_byte(p.dx, 2'b00);
    check("pkt_state11", current_state, 4'd11);
    repeat ($urandom_range(0, 3)) tick();
    rx_byte(p.dy, 2'b00);
    check("pkt_irq_state", current_state, 4'd12);
    check("pkt_irq",       mif.SEND_INTERRUPT, 1'b1);
    tick();
    check("pkt_irq_once",  mif.SEND_INTERRUPT, 1'b0);
    check("pkt_back9",     current_state, 4'd9);
    repeat ($urandom_range(1, 6)) tick();
    check("pkt_hold", {mif.MOUSE_STATUS, mif.MOUSE_DX, mif.MOUSE_DY},
          {p.status, p.exp_dx, p.exp_dy});
  endtask

  task automatic to_state3();
    int cyc;
    hold_reset(3);
    wait_send(cyc);
    check("s3_init_len", cyc, INIT_W);
    tick();
    pulse_sent();
    check("s3_reached", current_state, 4'd3);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    mif.BYTE_SENT       = 1'b0;
    mif.BYTE_READ       = 8'h00;
    mif.BYTE_ERROR_CODE = 2'b00;
    mif.BYTE_READY      = 1'b0;

    init_tbl[0] = '{8'hFA, 2'b00, 4'd4};
    init_tbl[1] = '{8'hAA, 2'b00, 4'd5};
    init_tbl[2] = '{8'h00, 2'b00, 4'd6};

    pkt_tbl[0] = '{8'h08, 8'h05, 8'hFE, 8'h05, 8'hFE};  // plain packet
    pkt_tbl[1] = '{8'h58, 8'h10, 8'h20, 8'h80, 8'h20};  // X overflow, X negative
    pkt_tbl[2] = '{8'h88, 8'h33, 8'h44, 8'h33, 8'h7F};  // Y overflow, Y positive
    pkt_tbl[3] = '{8'hE8, 8'h01, 8'h02, 8'h7F, 8'h80};  // both overflow, X pos, Y neg
    pkt_tbl[4] = '{8'h18, 8'hFF, 8'h00, 8'hFF, 8'h00};  // sign bit only, no clamp

    // Reset held 5 cycles, then full init.
    hold_reset(5);
    run_init();

    // Streaming state has no timeout; BYTE_READY absence just waits.
    repeat (120) tick();
    check("no_stream_timeout", current_state, 4'd9);

    for (int i = 0; i < 5; i++) send_packet(pkt_tbl[i]);

    // Reset after byte 2 of a packet: partial packet dropped, init restarts.
    rx_byte(8'h28, 2'b00);
    rx_byte(8'h11, 2'b00);
    check("partial_state", current_state, 4'd11);
    RESET = 1'b1;
    tick();
    check_cleared("midpkt_reset");
    hold_reset(2);
    run_init();
    send_packet(pkt_tbl[0]);

    // Wrong response in state 3.
    to_state3();
    rx_byte(8'hAA, 2'b00);
    check("wrong_resp_state", current_state, 4'd0);
    check("wrong_resp_send",  mif.SEND_BYTE, 1'b0);

    // Right byte but bad frame in state 3.
    to_state3();
    rx_byte(8'hFA, 2'b01);
    check("bad_frame_state", current_state, 4'd0);

    // No BYTE_SENT in state 2: timeout after RESP_T cycles; BYTE_READY ignored there.
    hold_reset(3);
    wait_send(cyc);
    tick();
    check("to2_entry", current_state, 4'd2);
    repeat (5) tick();
    rx_byte(8'hFA, 2'b00);
    check("to2_ignore_rx", current_state, 4'd2);
    repeat (RESP_T - 7) tick();
    check("to2_before", current_state, 4'd2);
    tick();
    check("to2_expired", current_state, 4'd0);

    // No response in state 3: timeout.
    to_state3();
    repeat (RESP_T - 1) tick();
    check("to3_before", current_state, 4'd3);
    tick();
    check("to3_expired", current_state, 4'd0);

    repeat (3) tick();
    check("all_packets_seen", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
